// File: rtl/line_chunk_sequencer_pkg.sv
// ============================================================================
// motion_defs : shared widths, chunk length and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package motion_defs;
   localparam int MAX_LINE_LENGTH = 10;
   localparam int X_COORD_W       = 11;
   localparam int Y_COORD_W       = 10;
   localparam int TIMEOUT_CYCLES  = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_BLANK  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_STREAM = 3'd4
   } seq_state_e;
endpackage

`default_nettype wire

// File: rtl/line_chunk_sequencer_chunk_unpacker.sv
// ============================================================================
// chunk_unpacker : holds one captured engine result and selects point idx
// Rev 1.0
// ============================================================================
`default_nettype none

module chunk_unpacker
   import motion_defs::*;
#(
   parameter int P_MAX_LINE_LENGTH = MAX_LINE_LENGTH,
   parameter int P_X_COORD_W       = X_COORD_W,
   parameter int P_Y_COORD_W       = Y_COORD_W,
   parameter int P_IDX_W           = $clog2(P_MAX_LINE_LENGTH + 1)
)(
   input  logic                                   i_clk,
   input  logic                                   i_reset_n,
   input  logic                                   i_capture,
   input  logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] i_x_vals,
   input  logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] i_y_vals,
   input  logic [P_MAX_LINE_LENGTH-1:0]           i_vals_valid,
   input  logic [P_IDX_W-1:0]                     i_idx,
   output logic [P_X_COORD_W-1:0]                 o_pt_x,
   output logic [P_Y_COORD_W-1:0]                 o_pt_y,
   output logic                                   o_pt_valid,
   output logic                                   o_exhausted
);

   logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] x_vals_q, x_vals_d;
   logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] y_vals_q, y_vals_d;
   logic [P_MAX_LINE_LENGTH-1:0]             valid_q, valid_d;

   logic [P_X_COORD_W-1:0] x_arr [P_MAX_LINE_LENGTH];
   logic [P_Y_COORD_W-1:0] y_arr [P_MAX_LINE_LENGTH];

   for (genvar k = 0; k < P_MAX_LINE_LENGTH; k++) begin : g_split
      assign x_arr[k] = x_vals_q[k*P_X_COORD_W +: P_X_COORD_W];
      assign y_arr[k] = y_vals_q[k*P_Y_COORD_W +: P_Y_COORD_W];
   end

   always_comb begin
      x_vals_d = i_capture ? i_x_vals     : x_vals_q;
      y_vals_d = i_capture ? i_y_vals     : y_vals_q;
      valid_d  = i_capture ? i_vals_valid : valid_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         x_vals_q <= '0;
         y_vals_q <= '0;
         valid_q  <= '0;
      end else begin
         x_vals_q <= x_vals_d;
         y_vals_q <= y_vals_d;
         valid_q  <= valid_d;
      end
   end

   // idx == P_MAX_LINE_LENGTH matches no entry and reads as exhausted
   always_comb begin
      o_pt_x     = '0;
      o_pt_y     = '0;
      o_pt_valid = 1'b0;
      for (int k = 0; k < P_MAX_LINE_LENGTH; k++) begin
         if (i_idx == P_IDX_W'(k)) begin
            o_pt_x     = x_arr[k];
            o_pt_y     = y_arr[k];
            o_pt_valid = valid_q[k];
         end
      end
      o_exhausted = !o_pt_valid;
   end

endmodule

`default_nettype wire

// File: rtl/line_chunk_sequencer.sv
// ============================================================================
// line_chunk_sequencer : splits a line request into engine-sized chunks
// and streams the resulting points. Rev 1.0
// ============================================================================
`default_nettype none

module line_chunk_sequencer
   import motion_defs::*;
#(
   parameter int P_MAX_LINE_LENGTH = MAX_LINE_LENGTH,
   parameter int P_X_COORD_W       = X_COORD_W,
   parameter int P_Y_COORD_W       = Y_COORD_W,
   parameter int P_TIMEOUT         = TIMEOUT_CYCLES
)(
   input  logic                                   i_clk,
   input  logic                                   i_reset_n,
   input  logic                                   i_req_valid,
   output logic                                   o_req_ready,
   input  logic [P_X_COORD_W-1:0]                 i_x0,
   input  logic [P_X_COORD_W-1:0]                 i_x1,
   input  logic [P_Y_COORD_W-1:0]                 i_y0,
   input  logic [P_Y_COORD_W-1:0]                 i_y1,
   output logic [P_X_COORD_W-1:0]                 o_eng_x0,
   output logic [P_X_COORD_W-1:0]                 o_eng_x1,
   output logic [P_Y_COORD_W-1:0]                 o_eng_y0,
   output logic [P_Y_COORD_W-1:0]                 o_eng_y1,
   output logic                                   o_eng_load,
   input  logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0] i_eng_x_vals,
   input  logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0] i_eng_y_vals,
   input  logic [P_MAX_LINE_LENGTH-1:0]           i_eng_vals_valid,
   input  logic                                   i_eng_vals_rdy,
   output logic                                   o_pt_valid,
   input  logic                                   i_pt_ready,
   output logic [P_X_COORD_W-1:0]                 o_pt_x,
   output logic [P_Y_COORD_W-1:0]                 o_pt_y,
   output logic                                   o_pt_last,
   output logic                                   o_busy,
   output logic                                   o_err
);

   localparam int IDX_W = $clog2(P_MAX_LINE_LENGTH + 1);
   localparam int CNT_W = $clog2(P_TIMEOUT + 1);

   seq_state_e             state_q, state_d;
   logic                   req_ready_q, req_ready_d;
   logic [P_X_COORD_W-1:0] cur_x_q, cur_x_d, end_x_q, end_x_d, last_x_q, last_x_d;
   logic [P_Y_COORD_W-1:0] cur_y_q, cur_y_d, end_y_q, end_y_d, last_y_q, last_y_d;
   logic                   chunk_first_q, chunk_first_d;
   logic                   emitted_q, emitted_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   capture;
   logic                   err;

   logic [P_X_COORD_W-1:0] sel_x;
   logic [P_Y_COORD_W-1:0] sel_y;
   logic                   sel_valid;
   logic                   exhausted;
   logic                   handshake;

   chunk_unpacker #(
      .P_MAX_LINE_LENGTH (P_MAX_LINE_LENGTH),
      .P_X_COORD_W       (P_X_COORD_W),
      .P_Y_COORD_W       (P_Y_COORD_W),
      .P_IDX_W           (IDX_W)
   ) u_unpacker (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_capture    (capture),
      .i_x_vals     (i_eng_x_vals),
      .i_y_vals     (i_eng_y_vals),
      .i_vals_valid (i_eng_vals_valid),
      .i_idx        (idx_q),
      .o_pt_x       (sel_x),
      .o_pt_y       (sel_y),
      .o_pt_valid   (sel_valid),
      .o_exhausted  (exhausted)
   );

   assign o_pt_valid  = (state_q == ST_STREAM) && sel_valid;
   assign o_pt_x      = sel_x;
   assign o_pt_y      = sel_y;
   assign o_pt_last   = o_pt_valid && (sel_x == end_x_q) && (sel_y == end_y_q);
   assign handshake   = o_pt_valid && i_pt_ready;
   assign o_req_ready = req_ready_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_eng_load  = (state_q == ST_LOAD);
   assign o_eng_x0    = cur_x_q;
   assign o_eng_y0    = cur_y_q;
   assign o_eng_x1    = end_x_q;
   assign o_eng_y1    = end_y_q;
   assign o_err       = err;

   always_comb begin
      state_d       = state_q;
      cur_x_d       = cur_x_q;
      cur_y_d       = cur_y_q;
      end_x_d       = end_x_q;
      end_y_d       = end_y_q;
      last_x_d      = last_x_q;
      last_y_d      = last_y_q;
      chunk_first_d = chunk_first_q;
      emitted_d     = emitted_q;
      idx_d         = idx_q;
      cnt_d         = '0;
      capture       = 1'b0;
      err           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_req_valid && req_ready_q) begin
               cur_x_d       = i_x0;
               cur_y_d       = i_y0;
               end_x_d       = i_x1;
               end_y_d       = i_y1;
               chunk_first_d = 1'b1;
               state_d       = ST_LOAD;
            end
         end
         ST_LOAD: begin
            emitted_d = 1'b0;
            state_d   = ST_BLANK;
         end
         // engine ready may still be left over from the previous chunk here
         ST_BLANK: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_eng_vals_rdy) begin
               capture = 1'b1;
               idx_d   = chunk_first_q ? IDX_W'(0) : IDX_W'(1);
               state_d = ST_STREAM;
            end else if (cnt_q == CNT_W'(P_TIMEOUT)) begin
               err     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STREAM: begin
            if (handshake) begin
               last_x_d  = sel_x;
               last_y_d  = sel_y;
               emitted_d = 1'b1;
               if (o_pt_last) state_d = ST_IDLE;
               else           idx_d   = idx_q + IDX_W'(1);
            end else if (exhausted) begin
               // restart from the last emitted point; entry 0 of the next chunk repeats it
               if (emitted_q) begin
                  cur_x_d       = last_x_q;
                  cur_y_d       = last_y_q;
                  chunk_first_d = 1'b0;
                  state_d       = ST_LOAD;
               end else begin
                  err     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b0;
         cur_x_q       <= '0;
         cur_y_q       <= '0;
         end_x_q       <= '0;
         end_y_q       <= '0;
         last_x_q      <= '0;
         last_y_q      <= '0;
         chunk_first_q <= 1'b0;
         emitted_q     <= 1'b0;
         idx_q         <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         cur_x_q       <= cur_x_d;
         cur_y_q       <= cur_y_d;
         end_x_q       <= end_x_d;
         end_y_q       <= end_y_d;
         last_x_q      <= last_x_d;
         last_y_q      <= last_y_d;
         chunk_first_q <= chunk_first_d;
         emitted_q     <= emitted_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_line_chunk_sequencer.sv
// ============================================================================
// tb_line_chunk_sequencer : directed and random lines against a chunking model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_chunk_sequencer;
   localparam int N  = 10;
   localparam int XW = 11;
   localparam int YW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            i_req_valid, o_req_ready;
   logic [XW-1:0]   i_x0, i_x1, o_eng_x0, o_eng_x1, o_pt_x;
   logic [YW-1:0]   i_y0, i_y1, o_eng_y0, o_eng_y1, o_pt_y;
   logic            o_eng_load;
   logic [N*XW-1:0] i_eng_x_vals;
   logic [N*YW-1:0] i_eng_y_vals;
   logic [N-1:0]    i_eng_vals_valid;
   logic            i_eng_vals_rdy;
   logic            o_pt_valid, i_pt_ready, o_pt_last, o_busy, o_err;

   line_chunk_sequencer dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
      .o_eng_x0(o_eng_x0), .o_eng_x1(o_eng_x1), .o_eng_y0(o_eng_y0), .o_eng_y1(o_eng_y1),
      .o_eng_load(o_eng_load),
      .i_eng_x_vals(i_eng_x_vals), .i_eng_y_vals(i_eng_y_vals),
      .i_eng_vals_valid(i_eng_vals_valid), .i_eng_vals_rdy(i_eng_vals_rdy),
      .o_pt_valid(o_pt_valid), .i_pt_ready(i_pt_ready),
      .o_pt_x(o_pt_x), .o_pt_y(o_pt_y), .o_pt_last(o_pt_last),
      .o_busy(o_busy), .o_err(o_err)
   );

   int vectors = 0;
   int miscompares = 0;
   bit eng_dead = 1'b0;

   int exp_x[$], exp_y[$], load_x[$], load_y[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bresenham points from start toward end, at most N of them
   function automatic int bres(input int sx, input int sy, input int ex, input int ey,
                               output int px[N], output int py[N]);
      int dx, dy, stx, sty, err, e2, x, y, n;
      dx  = (ex > sx) ? ex - sx : sx - ex;
      dy  = (ey > sy) ? ey - sy : sy - ey;
      stx = (ex >= sx) ? 1 : -1;
      sty = (ey >= sy) ? 1 : -1;
      err = dx - dy;
      x = sx; y = sy; n = 0;
      for (int k = 0; k < N; k++) begin px[k] = 0; py[k] = 0; end
      while (n < N) begin
         px[n] = x; py[n] = y; n++;
         if (x == ex && y == ey) break;
         e2 = 2 * err;
         if (e2 > -dy) begin err -= dy; x += stx; end
         if (e2 < dx)  begin err += dx; y += sty; end
      end
      return n;
   endfunction

   // Whole-line expectation: chain engine results, dropping the repeated first point
   task automatic build_expect(input int x0, input int y0, input int x1, input int y1);
      int cx, cy, n;
      int px[N], py[N];
      bit first, done;
      exp_x.delete(); exp_y.delete(); load_x.delete(); load_y.delete();
      cx = x0; cy = y0; first = 1'b1; done = 1'b0;
      for (int guard = 0; guard < 200 && !done; guard++) begin
         load_x.push_back(cx); load_y.push_back(cy);
         n = bres(cx, cy, x1, y1, px, py);
         for (int k = (first ? 0 : 1); k < n && !done; k++) begin
            exp_x.push_back(px[k]); exp_y.push_back(py[k]);
            if (px[k] == x1 && py[k] == y1) done = 1'b1;
         end
         cx = exp_x[$]; cy = exp_y[$]; first = 1'b0;
      end
   endtask

   // Engine: keeps stale ready through LOAD/BLANK, answers after random latency
   initial begin
      int cnt, lat, n;
      int px[N], py[N];
      cnt = -1; lat = 0;
      i_eng_vals_rdy = 1'b0; i_eng_x_vals = '0; i_eng_y_vals = '0; i_eng_vals_valid = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cnt = -1;
            continue;
         end
         if (o_eng_load) begin
            n   = bres(int'(o_eng_x0), int'(o_eng_y0), int'(o_eng_x1), int'(o_eng_y1), px, py);
            lat = $urandom_range(0, 4);
            cnt = 0;
         end else if (cnt >= 0) begin
            cnt++;
            if (cnt == 1) begin
               i_eng_vals_rdy   = 1'b0;
               i_eng_x_vals     = {4{$urandom}};
               i_eng_y_vals     = {4{$urandom}};
               i_eng_vals_valid = N'($urandom);
            end
            if (cnt >= 2 + lat && !eng_dead) begin
               for (int k = 0; k < N; k++) begin
                  if (k < n) begin
                     i_eng_x_vals[k*XW +: XW] = px[k][XW-1:0];
                     i_eng_y_vals[k*YW +: YW] = py[k][YW-1:0];
                  end
                  i_eng_vals_valid[k] = (k < n);
               end
               i_eng_vals_rdy = 1'b1;
               cnt = -1;
            end
         end
      end
   end

   task automatic send_req(input int x0, input int y0, input int x1, input int y1, input string name);
      int c;
      for (c = 0; c < 50 && !o_req_ready; c++) @(negedge clk);
      check({name, ".req_ready"}, 32'(o_req_ready), 32'd1);
      i_x0 = XW'(x0); i_y0 = YW'(y0); i_x1 = XW'(x1); i_y1 = YW'(y1);
      i_req_valid = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0;
   endtask

   // mode 0: ready always, 1: toggling 1010.., 2: random
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input int mode, input string name);
      int got, loads;
      bit finished, stall, rdy, sl;
      logic [XW-1:0] sx;
      logic [YW-1:0] sy;
      build_expect(x0, y0, x1, y1);
      got = 0; loads = 0; finished = 1'b0; stall = 1'b0; sx = '0; sy = '0; sl = 1'b0;
      send_req(x0, y0, x1, y1, name);
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         if (o_eng_load) begin
            if (loads < load_x.size()) begin
               check({name, ".load_x0"}, 32'(o_eng_x0), 32'(load_x[loads]));
               check({name, ".load_y0"}, 32'(o_eng_y0), 32'(load_y[loads]));
            end
            check({name, ".load_x1"}, 32'(o_eng_x1), 32'(x1));
            check({name, ".load_y1"}, 32'(o_eng_y1), 32'(y1));
            loads++;
         end
         if (stall) begin
            check({name, ".hold_valid"}, 32'(o_pt_valid), 32'd1);
            check({name, ".hold_x"}, 32'(o_pt_x), 32'(sx));
            check({name, ".hold_y"}, 32'(o_pt_y), 32'(sy));
            check({name, ".hold_last"}, 32'(o_pt_last), 32'(sl));
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         i_pt_ready = rdy;
         if (o_pt_valid && rdy) begin
            if (got < exp_x.size()) begin
               check({name, ".pt_x"}, 32'(o_pt_x), 32'(exp_x[got]));
               check({name, ".pt_y"}, 32'(o_pt_y), 32'(exp_y[got]));
               check({name, ".pt_last"}, 32'(o_pt_last), 32'(got == exp_x.size() - 1));
            end else begin
               check({name, ".extra_point"}, 32'(got), 32'(exp_x.size()));
            end
            got++;
            if (o_pt_last) finished = 1'b1;
         end
         stall = o_pt_valid && !rdy;
         sx = o_pt_x; sy = o_pt_y; sl = o_pt_last;
         @(negedge clk);
      end
      i_pt_ready = 1'b0;
      check({name, ".finished"}, 32'(finished), 32'd1);
      check({name, ".num_points"}, 32'(got), 32'(exp_x.size()));
      check({name, ".num_loads"}, 32'(loads), 32'(load_x.size()));
      check({name, ".idle_busy"}, 32'(o_busy), 32'd0);
      check({name, ".idle_ready"}, 32'(o_req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".req_ready"}, 32'(o_req_ready), 32'd0);
      check({name, ".busy"},      32'(o_busy),      32'd0);
      check({name, ".eng_load"},  32'(o_eng_load),  32'd0);
      check({name, ".pt_valid"},  32'(o_pt_valid),  32'd0);
      check({name, ".pt_last"},   32'(o_pt_last),   32'd0);
      check({name, ".err"},       32'(o_err),       32'd0);
      check({name, ".coords"},
            32'(o_pt_x) | 32'(o_pt_y) | 32'(o_eng_x0) | 32'(o_eng_x1) | 32'(o_eng_y0) | 32'(o_eng_y1),
            32'd0);
   endtask

   initial begin
      int k, got;
      rst_n = 1'b0;
      i_req_valid = 1'b0; i_pt_ready = 1'b0;
      i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset.ready_after", 32'(o_req_ready), 32'd1);
      check("reset.busy_after", 32'(o_busy), 32'd0);

      run_line(5, 5, 0, 0, 0, "diag_down");
      run_line(0, 0, 20, 0, 0, "horiz20");
      run_line(3, 3, 3, 3, 0, "zero_len");
      run_line(0, 0, 10, 10, 1, "toggle_ready");

      // engine never answers
      eng_dead = 1'b1;
      send_req(1, 1, 4, 4, "timeout");
      check("timeout.load", 32'(o_eng_load), 32'd1);
      for (k = 0; k < 100 && !o_err; k++) @(negedge clk);
      check("timeout.err_seen", 32'(o_err), 32'd1);
      check("timeout.err_cycle", 32'(k), 32'd66);
      @(negedge clk);
      check("timeout.err_pulse", 32'(o_err), 32'd0);
      check("timeout.ready_next", 32'(o_req_ready), 32'd1);
      eng_dead = 1'b0;

      // reset in the middle of streaming
      send_req(0, 0, 20, 0, "midreset");
      got = 0;
      i_pt_ready = 1'b1;
      for (k = 0; k < 200 && got < 5; k++) begin
         if (o_pt_valid) got++;
         @(negedge clk);
      end
      check("midreset.reached_stream", 32'(got), 32'd5);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      i_pt_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_line(5, 5, 0, 0, 0, "after_reset");

      for (int r = 0; r < 8; r++) begin
         run_line($urandom_range(0, 40), $urandom_range(0, 40),
                  $urandom_range(0, 40), $urandom_range(0, 40), 2, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
